// File: rtl/fdiv_pkg.sv
// Shared types and constants for the floor divider: FSM encoding, counter sizing
// and the quotient pattern returned on divide-by-zero.
package fdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Divide-by-zero quotient is this bit replicated across the result width.
    localparam logic DIV0_Q_BIT = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module fdiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_i < div_i always holds, so the trial result fits WIDTH bits when no borrow occurs.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, div_i};
        qbit_o  = ~trial[WIDTH];
        rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/floor_divider.sv
// Multi-cycle floor divider: magnitude restoring division followed by a sign
// fix-up so the quotient rounds toward minus infinity in signed mode.
module floor_divider
    import fdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0,
    output logic             ovf
);

    localparam int               CW      = clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic [WIDTH-1:0] braw_q, braw_d;
    logic             sa_q, sa_d, sb_q, sb_d, sgn_q, sgn_d, ovfp_q, ovfp_d;
    logic             busy_q, busy_d, done_q, done_d, div0_q, div0_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] quot_q, quot_d, rmd_q, rmd_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fix, r_fix;

    // acc_q holds the dividend magnitude and fills with quotient bits from the LSB.
    fdiv_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .div_i  (bmag_q),
        .bit_i  (acc_q[WIDTH-1]),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    always_comb begin
        q_fix = (sa_q ^ sb_q) ? (~acc_q + ONE) : acc_q;
        r_fix = sa_q ? (~rem_q + ONE) : rem_q;
        // Unsigned results never need the floor correction.
        if (sgn_q && (r_fix != '0) && (r_fix[WIDTH-1] != sb_q)) begin
            q_fix = q_fix - ONE;
            r_fix = r_fix + braw_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        bmag_d  = bmag_q;
        araw_d  = araw_q;
        braw_d  = braw_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sgn_d   = sgn_q;
        ovfp_d  = ovfp_q;
        busy_d  = busy_q;
        done_d  = done_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    araw_d  = dividend;
                    braw_d  = divisor;
                    sgn_d   = sgn;
                    sa_d    = sgn & dividend[WIDTH-1];
                    sb_d    = sgn & divisor[WIDTH-1];
                    acc_d   = (sgn & dividend[WIDTH-1]) ? (~dividend + ONE) : dividend;
                    bmag_d  = (sgn & divisor[WIDTH-1]) ? (~divisor + ONE) : divisor;
                    ovfp_d  = sgn && (dividend == MIN_VAL) && (divisor == '1);
                    rem_d   = '0;
                    cnt_d   = CNT_TOP;
                    state_d = (divisor == '0) ? DONE : DIV;
                end
            end
            DIV: begin
                rem_d = step_rem;
                acc_d = {acc_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                quot_d  = q_fix;
                rmd_d   = r_fix;
                div0_d  = 1'b0;
                ovf_d   = ovfp_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (done_q) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    // Only the divide-by-zero path arrives here without done set.
                    quot_d = {WIDTH{DIV0_Q_BIT}};
                    rmd_d  = araw_q;
                    div0_d = 1'b1;
                    ovf_d  = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            araw_q  <= '0;
            braw_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            sgn_q   <= 1'b0;
            ovfp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            araw_q  <= araw_d;
            braw_q  <= braw_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sgn_q   <= sgn_d;
            ovfp_q  <= ovfp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign div0      = div0_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_floor_divider.sv
// Directed bench for floor_divider: stimulus pushes expected results into a
// scoreboard queue that a forked monitor drains on every done pulse.
module tb_floor_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div0, ovf;
    logic [W-1:0] quotient, remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         d0;
        logic         ov;
        int           lat;
        int           t0;
        int           id;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    floor_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %h expected %h", name, id, act, exp);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", cyc, {31'b0, done}, '0);
                end else begin
                    e = sb_q.pop_front();
                    chk("quotient", e.id, quotient, e.q);
                    chk("remainder", e.id, remainder, e.r);
                    chk("div0", e.id, {31'b0, div0}, {31'b0, e.d0});
                    chk("ovf", e.id, {31'b0, ovf}, {31'b0, e.ov});
                    chk("latency", e.id, W'(cyc - e.t0), W'(e.lat));
                end
            end
        end
    endtask

    // Accepting edge is the posedge after the drive; expected latency counts edges after it.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed0,
                         input logic eov, input int elat, input int id);
        exp_t e;
        @(negedge clk);
        start = 1'b1; sgn = s; dividend = a; divisor = b;
        if (push) begin
            e.q = eq; e.r = er; e.d0 = ed0; e.ov = eov; e.lat = elat; e.t0 = cyc + 1; e.id = id;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003; sgn = ~s;
        chk("busy_rise", id, {31'b0, busy}, 32'd1);
    endtask

    task automatic pulse_junk_start();
        start = 1'b1; sgn = 1'b1; dividend = 32'h0000_0005; divisor = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, then pokes start in the done cycle; it must be ignored.
    task automatic wait_done(input int id);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_timeout", id, {31'b0, seen}, 32'd1);
        pulse_junk_start();
        chk("done_width", id, {31'b0, done}, '0);
        chk("busy_fall", id, {31'b0, busy}, '0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #23;
        chk("rst_busy", 0, {31'b0, busy}, '0);
        chk("rst_done", 0, {31'b0, done}, '0);
        chk("rst_quot", 0, quotient, '0);
        chk("rst_rem", 0, remainder, '0);
        chk("rst_div0", 0, {31'b0, div0}, '0);
        chk("rst_ovf", 0, {31'b0, ovf}, '0);
        @(negedge clk);
        rst = 1'b1;

        issue(0, 32'd9, 32'd5, 1, 32'd1, 32'd4, 0, 0, W + 1, 1);                                wait_done(1);
        issue(1, 32'hFFFF_FFF7, 32'd5, 1, 32'hFFFF_FFFE, 32'd1, 0, 0, W + 1, 2);               wait_done(2);
        issue(1, 32'd9, 32'hFFFF_FFFB, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0, W + 1, 3);       wait_done(3);
        issue(0, 32'd12, 32'd0, 1, 32'hFFFF_FFFF, 32'd12, 1, 0, 1, 4);                          wait_done(4);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0, 0, 1, W + 1, 5);       wait_done(5);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 0, 0, W + 1, 6);       wait_done(6);
        issue(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1, 32'd3, 32'hFFFF_FFFF, 0, 0, W + 1, 7);       wait_done(7);
        issue(1, 32'hFFFF_FFF8, 32'd2, 1, 32'hFFFF_FFFC, 32'd0, 0, 0, W + 1, 8);               wait_done(8);
        issue(0, 32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFF, 32'd0, 0, 0, W + 1, 9);               wait_done(9);
        issue(1, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 0, 1, 10);          wait_done(10);

        // Starts at cycles 5 and 20 of a running divide must not be accepted.
        issue(0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 0, 0, W + 1, 11);
        repeat (3) @(negedge clk);
        pulse_junk_start();
        repeat (14) @(negedge clk);
        pulse_junk_start();
        wait_done(11);

        // Reset at cycle 10 aborts the divide and clears everything at once.
        issue(0, 32'd100, 32'd7, 0, '0, '0, 0, 0, 0, 12);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 12, {31'b0, busy}, '0);
        chk("mid_rst_done", 12, {31'b0, done}, '0);
        chk("mid_rst_quot", 12, quotient, '0);
        chk("mid_rst_rem", 12, remainder, '0);
        chk("mid_rst_div0", 12, {31'b0, div0}, '0);
        chk("mid_rst_ovf", 12, {31'b0, ovf}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (W + 8) @(negedge clk);
        chk("post_rst_idle", 12, {31'b0, busy}, '0);
        chk("post_rst_quot", 12, quotient, '0);

        issue(0, 32'd150, 32'd12, 1, 32'd12, 32'd6, 0, 0, W + 1, 13);                          wait_done(13);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 0, W'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/floor_divider.md
# floor_divider

Parametrised multi-cycle floor-division unit for the VerySimpleCPU system, replacing the software shift-subtract division loop with a hardware engine. It accepts a dividend/divisor pair under a start/done handshake and returns quotient and remainder with floor semantics: unsigned, or signed rounding toward minus infinity. Divide-by-zero and signed overflow are flagged. It sits beside the CPU as a memory-mapped coprocessor; the address decode is outside this block.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request; sampled only in IDLE.
- sgn  in  1  1 = signed two's-complement floor division, 0 = unsigned.
- dividend  in  WIDTH  numerator a; latched on accepted start.
- divisor  in  WIDTH  denominator b; latched on accepted start.
- busy  out  1  high from the accepting edge until done falls.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- quotient  out  WIDTH  floor(a/b).
- remainder  out  WIDTH  a - b*quotient; sign matches the divisor, or 0.
- div0  out  1  divisor was zero.
- ovf  out  1  signed MIN / -1.

## Operation
- FSM states: IDLE, DIV, FIX, DONE.
- IDLE: on start=1, latch a, b and sgn.
  - Load |a| and |b|. Magnitudes are taken only when sgn=1; WIDTH+1-bit arithmetic, so |MIN| is representable.
  - Record sa and sb, the operand sign bits when sgn=1, else 0.
  - If b==0, go to DONE. Otherwise clear the partial remainder and bit counter, and go to DIV.
- DIV: restoring division, one quotient bit per cycle, MSB first, WIDTH cycles. The counter runs from WIDTH-1 down to 0, then the FSM goes to FIX.
- FIX: start from the truncated magnitude results q0 and r0.
  - q = (sa^sb) ? -q0 : q0.
  - r = sa ? -r0 : r0.
  - If r!=0 and sign(r)!=sb: q = q-1 and r = r+b.
  - All arithmetic is modulo 2^WIDTH. Then go to DONE.
- DONE: register the results, assert done for exactly one cycle, then return to IDLE.
  - quotient, remainder, div0 and ovf hold until the next accepted start.
- Divide by zero: quotient = all ones, remainder = dividend, div0=1, ovf=0.
- Overflow (sgn=1, a=MIN, b=-1): quotient = MIN (wrapped), remainder = 0, ovf=1.
- Unsigned mode never sets ovf.
- start in any state other than IDLE is ignored. No queueing.
- Operand inputs are don't-care except in the accepting cycle.

## Timing
- Reset (rst=0, asynchronous): FSM goes to IDLE. busy, done, quotient, remainder, div0 and ovf all become 0.
- Reset deasserts synchronously to clk in the system. Reset mid-operation aborts: no done pulse, and stale results are not restored.
- Normal latency: start is sampled at edge k. done is high in the cycle following edge k+WIDTH+1, i.e. WIDTH+2 cycles start-to-done.
- div0 latency: done is high in the cycle following edge k+1.
- busy rises after edge k and falls together with done.
- Back-to-back: start asserted during the done cycle is ignored, because the FSM is still in DONE. Earliest re-accept is the first IDLE cycle after done.
- Outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package fdiv_pkg:
  - state enum (IDLE/DIV/FIX/DONE);
  - counter width function clog2(WIDTH);
  - constant for the divide-by-zero quotient pattern.
- One natural sub-module: fdiv_step, the combinational single restoring step (partial remainder, divisor magnitude, next dividend bit -> new remainder, quotient bit). It is instantiated once; the datapath registers stay in floor_divider.

## Test plan
- Unsigned: WIDTH=32, sgn=0, a=9, b=5 -> quotient=1, remainder=4, div0=0, ovf=0; done exactly 34 cycles after the start edge.
- Signed negative dividend: sgn=1, a=-9, b=5 -> quotient=-2 (0xFFFFFFFE), remainder=1. Also a=9, b=-5 -> quotient=-2, remainder=-1 (0xFFFFFFFF).
- Divide by zero: a=12 (0xC), b=0 -> done 2 cycles after start, div0=1, quotient=0xFFFFFFFF, remainder=12.
- Signed overflow: sgn=1, a=0x80000000, b=0xFFFFFFFF -> ovf=1, quotient=0x80000000, remainder=0. The same operands with sgn=0 -> quotient=0, remainder=0x80000000, ovf=0.
- Busy protocol: pulse start again at cycles 5 and 20 of a divide of 100/7 -> ignored; single done, quotient=14, remainder=2.
- Reset mid-op: assert rst=0 at cycle 10 of a divide -> all outputs 0 immediately; no done. A fresh start of 150/12 after release -> quotient=12, remainder=6.
